// File: rtl/sram_mem_responder_pkg.sv
// sram_mem_responder_pkg: shared state encoding, defaults and address mapping for the SRAM responder
package sram_mem_responder_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LO_PHASE = 2'd1,
    HI_PHASE = 2'd2,
    DONE     = 2'd3
  } state_t;
  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int unsigned SRAM_DW = 16;
  localparam int unsigned SRAM_AW_DEF = 18;
  function automatic logic [31:0] word_index(input logic [31:0] address, input logic [31:0] base);
    return (address - base) >> 2;
  endfunction
endpackage

// File: rtl/sram_mem_responder_if.sv
// sram_mem_responder_if: MEM-stage load/store request bus between the pipeline and the responder
interface sram_mem_responder_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  modport master(output rd_en, wr_en, address, write_data, input read_data, ready);
  modport slave(input rd_en, wr_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_phase_counter.sv
// sram_phase_counter: per-phase cycle counter flagging the final cycle of a 16-bit SRAM phase
module sram_phase_counter #(
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] cnt,
  output logic       last
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 4'd1;
  assign last = cnt == 4'(PHASE_CYCLES - 1);
endmodule

// File: rtl/sram_mem_responder.sv
// sram_mem_responder: splits each 32-bit MEM-stage access into two timed 16-bit async SRAM phases
module sram_mem_responder
  import sram_mem_responder_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 2,
  parameter int unsigned BASE_ADDR    = BASE_ADDR_DEF,
  parameter int unsigned SRAM_AW      = SRAM_AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_mem_responder_if.slave  bus,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [SRAM_DW-1:0]   sram_dq_out,
  input  logic [SRAM_DW-1:0]   sram_dq_in,
  output logic                 sram_dq_oe,
  output logic                 sram_we_n
);
  state_t             state, state_n;
  logic [SRAM_AW-2:0] word;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               is_wr;
  logic               req;
  logic               phase;
  logic               hi;
  logic               last;
  logic [3:0]         cnt;
  assign req = bus.rd_en | bus.wr_en;
  sram_phase_counter #(.PHASE_CYCLES(PHASE_CYCLES)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (last),
    .en   (phase),
    .cnt  (cnt),
    .last (last)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // Only the IDLE-sampled request is used; a store wins over a simultaneous load.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      word  <= '0;
      wdata <= '0;
      is_wr <= 1'b0;
    end else if (state == IDLE && req) begin
      word  <= (SRAM_AW-1)'(word_index(bus.address, 32'(BASE_ADDR)));
      wdata <= bus.write_data;
      is_wr <= bus.wr_en;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (phase && !is_wr && last) begin
      if (hi) rdata[31:16] <= sram_dq_in;
      else rdata[15:0] <= sram_dq_in;
    end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     state_n = req ? LO_PHASE : IDLE;
      LO_PHASE: state_n = last ? HI_PHASE : LO_PHASE;
      HI_PHASE: state_n = last ? DONE : HI_PHASE;
      default:  state_n = IDLE;
    endcase
  end
  // With single-cycle phases there is no hold cycle, so the strobe covers the whole phase.
  always_comb begin
    phase       = state == LO_PHASE || state == HI_PHASE;
    hi          = state == HI_PHASE;
    bus.ready   = (state == IDLE && !req) || state == DONE;
    bus.read_data = rdata;
    sram_addr   = phase ? {word, hi} : '0;
    sram_dq_oe  = phase && is_wr;
    sram_dq_out = sram_dq_oe ? (hi ? wdata[31:16] : wdata[15:0]) : '0;
    sram_we_n   = !(sram_dq_oe && (!last || PHASE_CYCLES == 1));
  end
endmodule

// File: tb/tb_sram_mem_responder.sv
// tb_sram_mem_responder: three responders (PHASE_CYCLES 1, 2, 15) against SRAM models and a word-level reference
module tb_sram_mem_responder;
  localparam logic [2:0][3:0] PCV = {4'd15, 4'd2, 4'd1};
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en[3];
  logic        wr_en[3];
  logic [31:0] addr[3];
  logic [31:0] wdata[3];
  logic [31:0] rdata[3];
  logic        ready[3];
  logic [17:0] saddr[3];
  logic [15:0] dq_out[3];
  logic [15:0] dq_in[3];
  logic        oe[3];
  logic        we_n[3];
  logic [15:0] sram[3][262144];
  logic [31:0] ref_mem[int];
  logic [31:0] last_rd[3];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  generate
    for (genvar g = 0; g < 3; g++) begin : gi
      sram_mem_responder_if u_bus ();
      assign u_bus.rd_en      = rd_en[g];
      assign u_bus.wr_en      = wr_en[g];
      assign u_bus.address    = addr[g];
      assign u_bus.write_data = wdata[g];
      assign rdata[g]         = u_bus.read_data;
      assign ready[g]         = u_bus.ready;
      assign dq_in[g]         = sram[g][saddr[g]];
      sram_mem_responder #(.PHASE_CYCLES(int'(PCV[g]))) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (u_bus),
        .sram_addr   (saddr[g]),
        .sram_dq_out (dq_out[g]),
        .sram_dq_in  (dq_in[g]),
        .sram_dq_oe  (oe[g]),
        .sram_we_n   (we_n[g])
      );
    end
  endgenerate
  always @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (we_n[k] === 1'b0) sram[k][saddr[k]] <= dq_out[k];
  always @(negedge clk)
    if (rst === 1'b1)
      for (int k = 0; k < 3; k++) begin
        total++;
        assert (!(we_n[k] === 1'b0 && oe[k] !== 1'b1))
        else begin
          bad++;
          $error("FAIL we_n_without_oe inst=%0d we_n=%b oe=%b", k, we_n[k], oe[k]);
        end
      end
  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'(off[18:2]);
  endfunction
  function automatic int key(input int k, input logic [31:0] a);
    return k * 262144 + widx(a);
  endfunction
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input int k, input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    int lows = 0;
    bit seen = 0;
    int wi = widx(a);
    logic [31:0] exp;
    rd_en[k] = r;
    wr_en[k] = w;
    addr[k]  = a;
    wdata[k] = d;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready[k] === 1'b1) seen = 1;
      else lows++;
    end
    check32($sformatf("latency_i%0d", k), lows, 1 + 2 * int'(PCV[k]));
    if (w) begin
      ref_mem[key(k, a)] = d;
      check32($sformatf("sram_lo_i%0d", k), {16'h0, sram[k][2*wi]}, {16'h0, d[15:0]});
      check32($sformatf("sram_hi_i%0d", k), {16'h0, sram[k][2*wi+1]}, {16'h0, d[31:16]});
      check32($sformatf("rdata_kept_i%0d", k), rdata[k], last_rd[k]);
    end else begin
      exp = ref_mem.exists(key(k, a)) ? ref_mem[key(k, a)] : 32'hx;
      check32($sformatf("load_i%0d", k), rdata[k], exp);
      last_rd[k] = exp;
    end
    step();
    rd_en[k] = 1'b0;
    wr_en[k] = 1'b0;
  endtask
  initial begin
    logic [11:0] pat;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] first_a;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd_en[k] = 1'b0;
      wr_en[k] = 1'b0;
      addr[k] = '0;
      wdata[k] = '0;
      last_rd[k] = '0;
    end
    #3;
    for (int k = 0; k < 3; k++) begin
      check32($sformatf("rst_rdata_i%0d", k), rdata[k], 32'h0);
      check32($sformatf("rst_we_n_i%0d", k), {31'h0, we_n[k]}, 32'h1);
      check32($sformatf("rst_oe_i%0d", k), {31'h0, oe[k]}, 32'h0);
      check32($sformatf("rst_addr_i%0d", k), {14'h0, saddr[k]}, 32'h0);
      check32($sformatf("rst_dq_i%0d", k), {16'h0, dq_out[k]}, 32'h0);
    end
    #9 rst = 1'b1;
    step();
    check32("idle_ready", {31'h0, ready[1]}, 32'h1);
    txn(1, 1, 0, 32'd1024, 32'hDEADBEEF);
    check32("sram0", {16'h0, sram[1][0]}, 32'h0000BEEF);
    check32("sram1", {16'h0, sram[1][1]}, 32'h0000DEAD);
    txn(1, 0, 1, 32'd1024, 32'h0);
    txn(1, 1, 0, 32'd1032, 32'h12345678);
    check32("sram4", {16'h0, sram[1][4]}, 32'h00005678);
    check32("sram5", {16'h0, sram[1][5]}, 32'h00001234);
    txn(1, 1, 0, 32'd1020, 32'hAAAA5555);
    check32("wrap_lo", {16'h0, sram[1][18'h3FFFE]}, 32'h00005555);
    check32("wrap_hi", {16'h0, sram[1][18'h3FFFF]}, 32'h0000AAAA);
    txn(1, 1, 1, 32'd1028, 32'hA5A55A5A);
    check32("both_sram2", {16'h0, sram[1][2]}, 32'h00005A5A);
    check32("both_sram3", {16'h0, sram[1][3]}, 32'h0000A5A5);
    txn(1, 0, 1, 32'd1020, 32'h0);
    rd_en[1] = 1'b1;
    addr[1] = 32'd1032;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat[i] = ready[1];
      if (i == 5 || i == 11) check32($sformatf("held_load_c%0d", i), rdata[1], 32'h12345678);
      if (i == 7) begin
        @(posedge clk);
        #1 rd_en[1] = 1'b0;
      end
    end
    check32("held_ready_pattern", {20'h0, pat}, 32'h00000820);
    step();
    last_rd[1] = 32'h12345678;
    wr_en[1] = 1'b1;
    addr[1] = 32'd1040;
    wdata[1] = 32'hCAFEF00D;
    step();
    step();
    step();
    check32("hi_phase_we_n", {31'h0, we_n[1]}, 32'h0);
    #2 rst = 1'b0;
    #1;
    check32("midrst_we_n", {31'h0, we_n[1]}, 32'h1);
    check32("midrst_oe", {31'h0, oe[1]}, 32'h0);
    check32("midrst_rdata", rdata[1], 32'h0);
    wr_en[1] = 1'b0;
    for (int k = 0; k < 3; k++) last_rd[k] = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check32("post_rst_ready", {31'h0, ready[1]}, 32'h1);
    step();
    for (int k = 0; k < 3; k++) begin
      first_a = $urandom();
      for (int n = 0; n < 5; n++) begin
        a = (n == 0) ? first_a : $urandom();
        d = $urandom();
        txn(k, 1, 0, a, d);
        txn(k, 0, 1, a, 32'h0);
      end
      txn(k, 0, 1, first_a, 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
